// File: rtl/fixed_bias_add_stream.sv
// Streaming bias adder: joins data_in/bias beats, aligns binary points, requantises, emits via 2-entry skid buffer.
// Optional clamp on requantisation enabled by defining BIAS_ADD_SATURATE_EN (default: two's complement wrap).

module fixed_bias_add_lane #(
  parameter int P_IN0  = 16,
  parameter int P_IN1  = 3,
  parameter int P_B0   = 16,
  parameter int P_B1   = 3,
  parameter int P_OUT0 = 16,
  parameter int P_OUT1 = 3
) (
  input  logic [P_IN0-1:0]  i_din,
  input  logic [P_B0-1:0]   i_bias,
  output logic [P_OUT0-1:0] o_q
);
  localparam int SHB = P_IN1 - P_B1;
  localparam int SHO = P_IN1 - P_OUT1;
  localparam int SW  = ((P_IN0 > P_B0 + SHB) ? P_IN0 : P_B0 + SHB) + 1;

  logic signed [SW-1:0] w_din, w_b_al, w_sum, w_q;

  assign w_din  = $signed({{(SW-P_IN0){i_din[P_IN0-1]}}, i_din});
  assign w_b_al = $signed({{(SW-P_B0){i_bias[P_B0-1]}}, i_bias}) <<< SHB;
  assign w_sum  = w_din + w_b_al;
  assign w_q    = w_sum >>> SHO;

  generate
    if (SW >= P_OUT0) begin : g_narrow
`ifdef BIAS_ADD_SATURATE_EN
      localparam logic signed [SW-1:0] MAXV = {{(SW-P_OUT0+1){1'b0}}, {(P_OUT0-1){1'b1}}};
      localparam logic signed [SW-1:0] MINV = {{(SW-P_OUT0+1){1'b1}}, {(P_OUT0-1){1'b0}}};
      assign o_q = (w_q > MAXV) ? {1'b0, {(P_OUT0-1){1'b1}}} :
                   (w_q < MINV) ? {1'b1, {(P_OUT0-1){1'b0}}} : P_OUT0'(w_q);
`else
      assign o_q = P_OUT0'(w_q);
`endif
    end else begin : g_wide
      assign o_q = {{(P_OUT0-SW){w_q[SW-1]}}, w_q};
    end
  endgenerate
endmodule

module fixed_bias_add_stream #(
  parameter int DATA_IN_0_PRECISION_0  = 16,
  parameter int DATA_IN_0_PRECISION_1  = 3,
  parameter int BIAS_PRECISION_0       = 16,
  parameter int BIAS_PRECISION_1       = 3,
  parameter int DATA_OUT_0_PRECISION_0 = 16,
  parameter int DATA_OUT_0_PRECISION_1 = 3,
  parameter int TENSOR_SIZE_DIM_0      = 32,
  parameter int TENSOR_SIZE_DIM_1      = 4,
  parameter int PARALLELISM_DIM_0      = 1
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic [PARALLELISM_DIM_0-1:0][DATA_IN_0_PRECISION_0-1:0]    data_in,
  input  logic                                                       data_in_valid,
  output logic                                                       data_in_ready,
  input  logic [PARALLELISM_DIM_0-1:0][BIAS_PRECISION_0-1:0]         bias,
  input  logic                                                       bias_valid,
  output logic                                                       bias_ready,
  output logic [PARALLELISM_DIM_0-1:0][DATA_OUT_0_PRECISION_0-1:0]   data_out,
  output logic                                                       data_out_valid,
  input  logic                                                       data_out_ready,
  output logic                                                       data_out_last
);
  localparam int PAR       = PARALLELISM_DIM_0;
  localparam int P_OUT0    = DATA_OUT_0_PRECISION_0;
  localparam int COL_BEATS = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0;
  localparam int CW        = (COL_BEATS > 1) ? $clog2(COL_BEATS) : 1;
  localparam int RW        = (TENSOR_SIZE_DIM_1 > 1) ? $clog2(TENSOR_SIZE_DIM_1) : 1;

  generate
    if (BIAS_PRECISION_1 > DATA_IN_0_PRECISION_1) begin : g_chk_b
      $error("BIAS_PRECISION_1 must be <= DATA_IN_0_PRECISION_1");
    end
    if (DATA_OUT_0_PRECISION_1 > DATA_IN_0_PRECISION_1) begin : g_chk_o
      $error("DATA_OUT_0_PRECISION_1 must be <= DATA_IN_0_PRECISION_1");
    end
    if (TENSOR_SIZE_DIM_0 % PARALLELISM_DIM_0 != 0) begin : g_chk_p
      $error("PARALLELISM_DIM_0 must divide TENSOR_SIZE_DIM_0");
    end
  endgenerate

  logic [PAR-1:0][P_OUT0-1:0] w_sum;
  logic [PAR-1:0][P_OUT0-1:0] r_main_data, r_skid_data;
  logic                       r_main_vld, r_skid_vld, r_main_last, r_skid_last;
  logic [CW-1:0]              r_col;
  logic [RW-1:0]              r_row;
  logic                       w_space, w_fire, w_last;

  genvar gl;
  generate
    for (gl = 0; gl < PAR; gl++) begin : g_lane
      fixed_bias_add_lane #(
        .P_IN0 (DATA_IN_0_PRECISION_0), .P_IN1 (DATA_IN_0_PRECISION_1),
        .P_B0  (BIAS_PRECISION_0),      .P_B1  (BIAS_PRECISION_1),
        .P_OUT0(DATA_OUT_0_PRECISION_0), .P_OUT1(DATA_OUT_0_PRECISION_1)
      ) u_lane (
        .i_din (data_in[gl]),
        .i_bias(bias[gl]),
        .o_q   (w_sum[gl])
      );
    end
  endgenerate

  // Space depends only on registered skid state (plus reset), never on data_out_ready.
  assign w_space       = rst & ~r_skid_vld;
  assign w_fire        = data_in_valid & bias_valid & w_space;
  assign data_in_ready = bias_valid & w_space;
  assign bias_ready    = data_in_valid & w_space;
  assign w_last        = (r_col == CW'(COL_BEATS-1)) && (r_row == RW'(TENSOR_SIZE_DIM_1-1));

  assign data_out       = r_main_data;
  assign data_out_valid = r_main_vld;
  assign data_out_last  = r_main_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_main_vld  <= 1'b0;
      r_main_data <= '0;
      r_main_last <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
      r_skid_last <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
    end else begin
      if (w_fire) begin
        if (r_col == CW'(COL_BEATS-1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(TENSOR_SIZE_DIM_1-1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      // Main is free (empty or being consumed): refill from skid first, else straight from the join.
      if (!r_main_vld || data_out_ready) begin
        if (r_skid_vld) begin
          r_main_vld  <= 1'b1;
          r_main_data <= r_skid_data;
          r_main_last <= r_skid_last;
          r_skid_vld  <= 1'b0;
        end else begin
          r_main_vld <= w_fire;
          if (w_fire) begin
            r_main_data <= w_sum;
            r_main_last <= w_last;
          end
        end
      end else if (w_fire) begin
        r_skid_vld  <= 1'b1;
        r_skid_data <= w_sum;
        r_skid_last <= w_last;
      end
    end
  end
endmodule
